// File: rtl/sp_mult_ctrl.sv
// ---------------------------------------------------------------------------
// sp_mult_ctrl
// Sequencer for the serial-parallel multiplier array. It accepts an operand
// pair through a start/ready handshake, holds the multiplicand on arr_y as the
// parallel operand, and streams the multiplier into the array LSB-first.
// After WIDTH multiplier bits it feeds WIDTH zeros so the array can flush its
// carries. The serial product bits returned on arr_p are assembled into a
// 2*WIDTH-bit result, and a one-cycle done pulse marks its arrival.
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   rst_n         synchronous active-low reset
//   start         operation request, taken only while ready=1
//   multiplicand  parallel operand, captured on the accepting edge
//   multiplier    serial operand, captured on the accepting edge
//   ready         high in IDLE
//   busy          high in CLEAR and RUN
//   done          one-cycle pulse; product is valid from this cycle
//   product       last completed result, held until the next done
//   arr_clr       clears the array carry/sum registers (CLEAR only)
//   arr_en        array clock enable (RUN only)
//   arr_y         latched multiplicand
//   arr_x         current serial multiplier bit, 0 outside RUN
//   arr_p         serial product bit from the array, valid while arr_en=1
// ---------------------------------------------------------------------------
module sp_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               arr_clr,
  output logic               arr_en,
  output logic [WIDTH-1:0]   arr_y,
  output logic               arr_x,
  input  logic               arr_p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PW - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_reg,   state_next;
  logic [CW-1:0]    cnt_reg,     cnt_next;
  logic [WIDTH-1:0] x_sr_reg,    x_sr_next;
  logic [WIDTH-1:0] y_reg,       y_next;
  logic [PW-1:0]    psr_reg,     psr_next;
  logic [PW-1:0]    product_reg, product_next;

  // Product shift register moved one place right with the new array bit at
  // the MSB; after 2*WIDTH shifts the bit from RUN cycle k sits at bit k.
  logic [PW-1:0] psr_shift;

  generate
    for (genvar gi = 0; gi < PW - 1; gi++) begin : g_psr_shift
      assign psr_shift[gi] = psr_reg[gi+1];
    end
  endgenerate
  assign psr_shift[PW-1] = arr_p;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    x_sr_next    = x_sr_reg;
    y_next       = y_reg;
    psr_next     = psr_reg;
    product_next = product_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          y_next     = multiplicand;
          x_sr_next  = multiplier;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_next   = '0;
        psr_next   = '0;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        // Zero fill supplies the flush bits once the multiplier is used up.
        x_sr_next = {1'b0, x_sr_reg[WIDTH-1:1]};
        psr_next  = psr_shift;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST_CNT) begin
          // Capture straight from the shift input so the result is already
          // on product in the DONE cycle.
          product_next = psr_shift;
          state_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      x_sr_reg    <= '0;
      y_reg       <= '0;
      psr_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      x_sr_reg    <= x_sr_next;
      y_reg       <= y_next;
      psr_reg     <= psr_next;
      product_reg <= product_next;
    end
  end

  // Handshake and array controls come from the registered state only.
  assign ready   = (state_reg == ST_IDLE);
  assign busy    = (state_reg == ST_CLEAR) || (state_reg == ST_RUN);
  assign done    = (state_reg == ST_DONE);
  assign arr_clr = (state_reg == ST_CLEAR);
  assign arr_en  = (state_reg == ST_RUN);
  assign arr_x   = (state_reg == ST_RUN) && x_sr_reg[0];
  assign arr_y   = y_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_sp_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sp_mult_ctrl
// Self-checking bench for sp_mult_ctrl (WIDTH=8). An ideal serial-parallel
// array is modelled behaviourally: each RUN cycle adds arr_x*arr_y into an
// accumulator, emits its LSB on arr_p and shifts it right. Expected products
// come from plain multiplication. Some tests drive arr_p directly instead.
// ---------------------------------------------------------------------------
module tb_sp_mult_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           ready, busy, done, arr_clr, arr_en, arr_x, arr_p;
  logic [2*W-1:0] product;
  logic [W-1:0]   arr_y;

  logic           use_manual = 1'b0;
  logic           manual_p = 1'b0;
  logic [2*W-1:0] acc = '0;
  logic [2*W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  sp_mult_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .arr_clr      (arr_clr),
    .arr_en       (arr_en),
    .arr_y        (arr_y),
    .arr_x        (arr_x),
    .arr_p        (arr_p)
  );

  always #5 clk = ~clk;

  // Ideal array: serial partial-product accumulation.
  always_comb begin
    sum   = acc + (arr_x ? {{W{1'b0}}, arr_y} : '0);
    arr_p = use_manual ? manual_p : sum[0];
  end

  always @(posedge clk) begin
    if (arr_clr)     acc <= '0;
    else if (arr_en) acc <= sum >> 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one operation while ready and waits (bounded) for done.
  // lat = cycles from accepting edge to done (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [2*W-1:0] p,
                        output logic [2*W-1:0] p_clear);
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b;
    @(negedge clk);
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    p_clear = product;
    lat = -1; p = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin lat = c; p = product; break; end
      @(negedge clk);
    end
    $display("op %0d*%0d -> product=%0d latency=%0d", a, b, p, lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; mcand = 8'hFF; mplier = 8'hFF;
    repeat (3) @(negedge clk);
    n_cmp++; if ({ready, busy, done, arr_en, arr_clr, arr_x} !== 6'b100000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 100000", {ready, busy, done, arr_en, arr_clr, arr_x});
    end
    n_cmp++; if (product !== '0 || arr_y !== '0) begin
      n_err++; $display("FAIL reset_data: product=%h arr_y=%h want 0/0", product, arr_y);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready !== 1'b1 || busy !== 1'b0 || arr_clr !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: ready=%b busy=%b clr=%b want 1/0/0", ready, busy, arr_clr);
    end
    $display("reset: done");
  endtask

  task automatic test_bit_order;
    logic [W-1:0] mp;
    logic         ex;
    mp = 8'hA5;
    use_manual = 1'b1; manual_p = 1'b0;
    @(negedge clk);
    start = 1'b1; mcand = 8'h3C; mplier = mp;
    @(negedge clk);  // cycle 1: CLEAR
    start = 1'b0;
    n_cmp++; if (arr_clr !== 1'b1 || arr_en !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL order_clear: clr=%b en=%b busy=%b want 1/0/1", arr_clr, arr_en, busy);
    end
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);  // RUN cycle k
      ex = (k < W) ? mp[k] : 1'b0;
      manual_p = (k == 0 || k == 3 || k == 15);
      n_cmp++; if (arr_en !== 1'b1 || arr_clr !== 1'b0 || done !== 1'b0 || arr_x !== ex) begin
        n_err++; $display("FAIL order_run%0d: en=%b clr=%b done=%b x=%b want 1/0/0/%b", k, arr_en, arr_clr, done, arr_x, ex);
      end
    end
    @(negedge clk);  // cycle 18
    manual_p = 1'b0;
    n_cmp++; if (done !== 1'b1 || product !== 16'h8009 || arr_y !== 8'h3C) begin
      n_err++; $display("FAIL order_done: done=%b product=%h arr_y=%h want 1/8009/3c", done, product, arr_y);
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || ready !== 1'b1 || product !== 16'h8009 || arr_x !== 1'b0) begin
      n_err++; $display("FAIL order_after: done=%b ready=%b product=%h x=%b", done, ready, product, arr_x);
    end
    use_manual = 1'b0;
    $display("bit order: A5 stream checked");
  endtask

  task automatic test_functional;
    logic [W-1:0]   av [4] = '{8'd13, 8'd255, 8'd0, 8'd1};
    logic [W-1:0]   bv [4] = '{8'd11, 8'd255, 8'd200, 8'd255};
    logic [2*W-1:0] prev, p, pc;
    int lat;
    prev = 16'h8009;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], lat, p, pc);
      n_cmp++; if (pc !== prev) begin
        n_err++; $display("FAIL func_hold%0d: product=%0d want %0d", i, pc, prev);
      end
      n_cmp++; if (lat !== 18 || p !== av[i] * bv[i]) begin
        n_err++; $display("FAIL func%0d: product=%0d lat=%0d want %0d/18", i, p, lat, av[i] * bv[i]);
      end
      prev = av[i] * bv[i];
    end
  endtask

  task automatic test_start_while_busy;
    int ndone, dcyc;
    @(negedge clk);
    start = 1'b1; mcand = 8'd3; mplier = 8'd4;
    ndone = 0; dcyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin ndone++; if (dcyc < 0) dcyc = c; end
      start = (c == 1 || c == 7 || c == 18);
      mcand = 8'd9; mplier = 8'd9;
    end
    n_cmp++; if (ndone !== 1 || dcyc !== 18 || product !== 16'd12) begin
      n_err++; $display("FAIL busy_ignore: pulses=%0d at=%0d product=%0d want 1/18/12", ndone, dcyc, product);
    end
    $display("start while busy: pulses=%0d product=%0d", ndone, product);
  endtask

  task automatic test_back_to_back;
    int d1, d2;
    logic [2*W-1:0] p1, p2;
    @(negedge clk);
    start = 1'b1; mcand = 8'd7; mplier = 8'd6;
    d1 = -1; d2 = -1; p1 = '0; p2 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin d1 = c; p1 = product; end
        else begin d2 = c; p2 = product; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    n_cmp++; if (d1 !== 18 || d2 - d1 !== 19) begin
      n_err++; $display("FAIL b2b_timing: done at %0d and %0d want 18 and 37", d1, d2);
    end
    n_cmp++; if (p1 !== 16'd42 || p2 !== 16'd42) begin
      n_err++; $display("FAIL b2b_product: %0d %0d want 42 42", p1, p2);
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_idle: ready=%b want 1", ready);
    end
    $display("back to back: done at %0d and %0d", d1, d2);
  endtask

  task automatic test_reset_mid_run;
    int ndone, lat;
    logic [2*W-1:0] p, pc;
    @(negedge clk);
    start = 1'b1; mcand = 8'd200; mplier = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);  // RUN cycle 6
    n_cmp++; if (arr_en !== 1'b1) begin
      n_err++; $display("FAIL midrun_pre: arr_en=%b want 1", arr_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if ({ready, busy, done, arr_en, arr_clr, arr_x} !== 6'b100000 || arr_y !== '0 || product !== '0) begin
      n_err++; $display("FAIL midrun_reset: ctrl=%b arr_y=%h product=%h want 100000/0/0",
                        {ready, busy, done, arr_en, arr_clr, arr_x}, arr_y, product);
    end
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin
      n_err++; $display("FAIL midrun_nodone: pulses=%0d want 0", ndone);
    end
    run_op(8'd5, 8'd5, lat, p, pc);
    n_cmp++; if (p !== 16'd25 || lat !== 18) begin
      n_err++; $display("FAIL midrun_after: product=%0d lat=%0d want 25/18", p, lat);
    end
  endtask

  task automatic test_random;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p, pc;
    int lat;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(a, b, lat, p, pc);
      n_cmp++; if (p !== a * b || lat !== 18) begin
        n_err++; $display("FAIL rand%0d: %0d*%0d product=%0d lat=%0d want %0d/18", i, a, b, p, lat, a * b);
      end
    end
  endtask

  initial begin
    test_reset;
    test_bit_order;
    test_functional;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sp_mult_ctrl.md
Name: sp_mult_ctrl

Overview:
Sequencer for the serial-parallel multiplier datapath (the half-adder/full-adder array with carry/sum registers).
- Accepts operands through a start/ready handshake and latches the multiplicand as the parallel operand.
- Streams the multiplier into the array LSB-first, then zero-flushes.
- Assembles the serial product bits into a 2*WIDTH-bit result.
- Signals completion with a one-cycle done pulse.
- Sits between the top-level operand interface and the array; holds no arithmetic of its own.

Parameters:
WIDTH, 8, operand width in bits; legal range 2 to 32; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request a multiplication; accepted only when ready=1
multiplicand  input  WIDTH  parallel operand, sampled on the accepting edge
multiplier  input  WIDTH  serial operand, sampled on the accepting edge
ready  output  1  high only in IDLE
busy  output  1  high in CLEAR and RUN
done  output  1  one-cycle pulse in DONE; product valid from this cycle
product  output  2*WIDTH  last completed result; holds until the next DONE
arr_clr  output  1  clears array carry/sum registers; high only in CLEAR
arr_en  output  1  array clock enable; high only in RUN
arr_y  output  WIDTH  latched multiplicand, stable for the whole operation
arr_x  output  1  current serial multiplier bit; 0 outside RUN
arr_p  input  1  serial product bit from array, combinationally valid while arr_en=1

Behaviour:
- Reset (rst_n=0 at an edge), effective from the next cycle:
  - state=IDLE; ready=1; busy=0; done=0; arr_clr=0; arr_en=0; arr_x=0.
  - arr_y=0; product=0; internal cycle counter=0; multiplier and product shift registers=0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- FSM states: IDLE, CLEAR, RUN, DONE.
  - IDLE: start=1 at an edge latches multiplicand into arr_y and multiplier into x_sr, then goes to CLEAR.
  - CLEAR: exactly one cycle with arr_clr=1 and arr_en=0. Counter=0 and the product shift register is cleared. Goes to RUN.
  - RUN: exactly 2*WIDTH cycles with arr_en=1.
    - arr_x = x_sr[0].
    - Each edge shifts x_sr right with 0 fill, so cycles 0..WIDTH-1 carry multiplier bits LSB-first and cycles WIDTH..2*WIDTH-1 carry 0 (flush).
    - Each edge shifts the product register right, inserting arr_p at the MSB; after the final RUN edge, bit k equals arr_p sampled in RUN cycle k.
    - Counter increments each edge. Leave RUN when counter = 2*WIDTH-1 at the edge.
  - DONE: one cycle. done=1; product output register updated from the assembled value at entry to DONE. Goes to IDLE unconditionally.
- Latency:
  - start accepted at edge E0; CLEAR occupies cycle 1; RUN occupies cycles 2..2*WIDTH+1; done is high in cycle 2*WIDTH+2.
  - ready returns in cycle 2*WIDTH+3. For WIDTH=8: done in cycle 18 after the accepting edge; throughput one result per 19 cycles.
- Handshake and holding:
  - start while ready=0 (CLEAR, RUN, DONE) is ignored, not queued.
  - start held high continuously begins the next operation on the first IDLE edge.
  - Operand inputs are don't-care except on the accepting edge.
  - arr_y holds its value through DONE and IDLE until the next acceptance.
- product retains the previous result during a new operation; it changes only on DONE entry or reset.
- Counter width is clog2(2*WIDTH)+1 bits; no wrap occurs within an operation.
- Outputs ready, busy, done, arr_clr and arr_en are decoded from the registered state only, with no combinational path from start.

Test Plan:
1. Reset and idle: hold rst_n=0 for 3 cycles with start=1 -> ready=1, busy=0, done=0, product=0, arr_en=0, arr_clr=0, arr_x=0, arr_y=0. Release with start=0 -> FSM stays in IDLE.
2. Bit ordering, with the bench driving arr_p directly: multiplier=8'hA5; drive arr_p=1 only in RUN cycles 0, 3 and 15 -> arr_x sequence is 1,0,1,0,0,1,0,1 then eight 0s; arr_clr high exactly 1 cycle before the first arr_en; done in cycle 18; product=16'h8009.
3. Functional, with an ideal array model in the bench: 13*11 -> product=16'd143; 255*255 -> 16'd65025; 0*200 -> 0; 1*255 -> 255. Each result held until the next done.
4. Start while busy: start=1 with operands 3,4 accepted, then start pulses with 9,9 in CLEAR, RUN cycle 5 and DONE -> all ignored; product=12; exactly one done pulse.
5. Back-to-back: start held high with operands 7,6 -> second operation accepted on the IDLE edge after DONE; done pulses exactly 19 cycles apart; both products equal 42.
6. Reset mid-RUN: rst_n=0 in RUN cycle 6 of 200*3 -> next cycle is IDLE with all outputs at reset values, no done pulse. A subsequent 5*5 gives product=25.
